load_mem_unit: RTL and testbench
================================

// Module: load_mem_unit
// PURPOSE
//  Execute/memory stage for RISC-V loads, directly downstream of the load decoder.
//  Takes the decoded rs1 value, imm, rd and load_control; forms the effective address and
//  issues a word read on a req/gnt/rvalid memory port. Byte/half lanes are extracted and
//  sign- or zero-extended. The result is presented to writeback on a valid/ready handshake.
// PARAMETERS
//  XLEN    32  data/register width
//  ADDR_W  32  byte-address width (== XLEN in this design)
// PORTS
//  clk           in   1       clock, all state on rising edge
//  reset         in   1       synchronous, active-high
//  ld_valid      in   1       decoded load presented
//  ld_ready      out  1       unit can accept (high only in IDLE)
//  rs1_data      in   XLEN    base register value
//  imm           in   12      signed offset from decoder
//  rd            in   5       destination register
//  load_control  in   3       LB/LH/LW/LBU/LHU/LD_NOP encoding from processor_defines.sv
//  mem_req       out  1       read request
//  mem_addr      out  ADDR_W  word-aligned address {ea[31:2],2'b00}
//  mem_gnt       in   1       request accepted
//  mem_rvalid    in   1       read data valid
//  mem_rdata     in   XLEN    read word
//  wb_valid      out  1       load result valid
//  wb_rd         out  5       destination register
//  wb_data       out  XLEN    extended load result
//  wb_ready      in   1       writeback accepts
//  misalign      out  1       1-cycle misaligned-load pulse (tied 0 without macro)
// BEHAVIOUR
//  - One clock; reset synchronous, active-high. On reset: state IDLE, mem_req=0, mem_addr=0,
//    wb_valid=0, wb_rd=0, wb_data=0, misalign=0. ld_ready=1 from the first cycle after reset.
//  - FSM IDLE->REQ->WAIT->RESP->IDLE. One load in flight; no pipelining.
//  - IDLE: ld_ready=1. On ld_valid, capture ea = rs1_data + sext(imm), mod 2^32 (wraps),
//    plus control and rd. LD_NOP: nothing captured, no request, no writeback, stay IDLE.
//  - REQ: mem_req=1 and mem_addr stable until mem_gnt; on gnt -> WAIT.
//  - WAIT: mem_rvalid is only valid from the cycle after gnt. On rvalid, register the
//    extracted data -> RESP.
//  - RESP: wb_valid=1 and wb_rd/wb_data held until wb_ready; on ready -> IDLE. ld_ready stays
//    0 in the handoff cycle; the next accept is one cycle later.
//  - Minimum latency: accept at cycle N, gnt at N+1, rvalid at N+2, wb_valid at N+3.
//  - Extraction: LB/LBU take byte ea[1:0]*8; LH/LHU take half ea[1]*16; LW takes the full word.
//    LB/LH sign-extend; LBU/LHU zero-extend.
//  - rd==0 loads do access memory and do write back with wb_rd=0; the regfile discards them.
//  - mem_rvalid outside WAIT is ignored. mem_rvalid in the gnt cycle is ignored.
//  - Reset mid-operation returns to IDLE at that edge and drops mem_req. A late rvalid after
//    reset is ignored.
// CONFIGURATION
//  LD_MISALIGN_CHECK_EN defined:
//    - LH/LHU with ea[0]=1, or LW with ea[1:0]!=0, issues no memory request and no writeback.
//    - misalign=1 for exactly one cycle (the cycle after accept), then IDLE.
//  LD_MISALIGN_CHECK_EN undefined:
//    - misalign is tied 0.
//    - Offsets are truncated: LH uses lane ea[1], LW ignores ea[1:0].
// STRUCTURE
//  - processor_pkg: ld_state_t enum {IDLE,REQ,WAIT,RESP}, and load_ctrl_t mirroring the
//    LB/LH/LW/LBU/LHU/LD_NOP values of processor_defines.sv.
//  - Sub-module load_data_align (combinational): (rdata, ea[1:0], control) -> extended word.
//    Reused later by a store-forwarding path.
// TESTING
//  - LW rs1=0x1000, imm=0x004, mem word 0xDEADBEEF, gnt/rvalid immediate
//    -> mem_addr=0x1004; wb_data=0xDEADBEEF at accept+3.
//  - LB ea=0x2003, word 0x80FF_0000 -> wb_data=0xFFFFFF80.
//    LBU, same ea and word -> 0x00000080.
//  - LH rs1=0x10, imm=0xFFE (-2) -> ea=0x0E, mem_addr=0x0C, half ea[1]=1.
//    Word 0x8001_1234 -> wb_data=0xFFFF8001.
//  - gnt delayed 3 cycles, wb_ready low 2 cycles -> mem_req, mem_addr, wb_valid, wb_data all
//    held stable; exactly one writeback.
//  - LD_NOP on ld_valid -> no mem_req, no wb_valid.
//    Reset asserted in WAIT, then rvalid -> no writeback, ld_ready=1.
//  - Macro on: LW ea=0x1002 -> misalign pulse of 1 cycle, mem_req never set.
//    Macro off: same LW -> mem_addr=0x1000, full word written back.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared load-path types: FSM state encoding, load-control encoding and a misalignment helper.
package processor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } ld_state_t;

    // Values track the funct3-style encoding used by processor_defines.sv.
    typedef enum logic [2:0] {
        LB     = 3'b000,
        LH     = 3'b001,
        LW     = 3'b010,
        LBU    = 3'b100,
        LHU    = 3'b101,
        LD_NOP = 3'b111
    } load_ctrl_t;

    function automatic logic is_misaligned(input load_ctrl_t ctrl, input logic [1:0] ea_lo);
        case (ctrl)
            LH, LHU: return ea_lo[0];
            LW:      return (ea_lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_data_align.sv
// Combinational lane select and sign/zero extension of a loaded word; shared with store forwarding.
module load_data_align
    import processor_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      ea_lo,
    input  load_ctrl_t      control,
    output logic [XLEN-1:0] data
);

    logic [7:0]  lanes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lanes[gi] = rdata[gi*8 +: 8];
    end

    always_comb begin
        byte_sel = lanes[ea_lo];
        half_sel = ea_lo[1] ? {lanes[3], lanes[2]} : {lanes[1], lanes[0]};
        data     = '0;
        case (control)
            LB:      data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LBU:     data = {{(XLEN-8){1'b0}}, byte_sel};
            LH:      data = {{(XLEN-16){half_sel[15]}}, half_sel};
            LHU:     data = {{(XLEN-16){1'b0}}, half_sel};
            LW:      data = rdata;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_mem_unit.sv
// RISC-V load execute/memory stage: EA calc, req/gnt/rvalid word read, extend, valid/ready writeback.
// Optional misaligned-load trap enabled by defining LD_MISALIGN_CHECK_EN.
module load_mem_unit
    import processor_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [11:0]       imm,
    input  logic [4:0]        rd,
    input  logic [2:0]        load_control,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    input  logic              wb_ready,
    output logic              misalign
);

    ld_state_t         state_reg, state_next;
    logic [ADDR_W-1:0] ea_reg;
    logic [ADDR_W-1:0] ea_next;
    load_ctrl_t        ctrl_reg;
    load_ctrl_t        ctrl_in;
    logic [4:0]        rd_reg;
    logic [XLEN-1:0]   wb_data_reg;
    logic [XLEN-1:0]   aligned_data;
    logic              accept;
    logic              bad_align;

    assign ctrl_in = load_ctrl_t'(load_control);
    assign ea_next = rs1_data + {{(XLEN-12){imm[11]}}, imm};
    assign accept  = (state_reg == IDLE) && ld_valid && (ctrl_in != LD_NOP);

`ifdef LD_MISALIGN_CHECK_EN
    logic misalign_reg;
    assign bad_align = is_misaligned(ctrl_in, ea_next[1:0]);
    assign misalign  = misalign_reg;

    always_ff @(posedge clk) begin
        if (reset) misalign_reg <= 1'b0;
        else       misalign_reg <= accept && bad_align;
    end
`else
    // Without the check, low address bits simply select lanes (LW ignores them).
    assign bad_align = 1'b0;
    assign misalign  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept && !bad_align) state_next = REQ;
            REQ:  if (mem_gnt)              state_next = WAIT;
            WAIT: if (mem_rvalid)           state_next = RESP;
            RESP: if (wb_ready)             state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    load_data_align #(.XLEN(XLEN)) u_align (
        .rdata   (mem_rdata),
        .ea_lo   (ea_reg[1:0]),
        .control (ctrl_reg),
        .data    (aligned_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ea_reg      <= '0;
            ctrl_reg    <= LD_NOP;
            rd_reg      <= '0;
            wb_data_reg <= '0;
        end else begin
            if (accept && !bad_align) begin
                ea_reg   <= ea_next;
                ctrl_reg <= ctrl_in;
                rd_reg   <= rd;
            end
            // Only a response arriving in WAIT counts; gnt-cycle or stray rvalid is dropped.
            if (state_reg == WAIT && mem_rvalid)
                wb_data_reg <= aligned_data;
        end
    end

    assign ld_ready = (state_reg == IDLE);
    assign mem_req  = (state_reg == REQ);
    assign mem_addr = {ea_reg[ADDR_W-1:2], 2'b00};
    assign wb_valid = (state_reg == RESP);
    assign wb_rd    = rd_reg;
    assign wb_data  = wb_data_reg;

endmodule

// File: tb/tb_load_mem_unit.sv
// Directed table-driven bench for load_mem_unit; covers misalignment behaviour with or without LD_MISALIGN_CHECK_EN.
module tb_load_mem_unit;
    import processor_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] rs1_data;
    logic [11:0] imm;
    logic [4:0]  rd;
    logic [2:0]  load_control;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        misalign;

    int n_vec   = 0;
    int n_fail  = 0;
    int wb_count = 0;

    typedef struct {
        logic [2:0]  ctrl;
        logic [31:0] rs1;
        logic [11:0] imm;
        logic [4:0]  rd;
        logic [31:0] word;
        logic [31:0] addr;
        logic [31:0] data;
        int          gnt_dly;
        int          rdy_dly;
    } vec_t;

    vec_t vecs[8];

    load_mem_unit dut (
        .clk          (clk),
        .reset        (reset),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .rs1_data     (rs1_data),
        .imm          (imm),
        .rd           (rd),
        .load_control (load_control),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_ready     (wb_ready),
        .misalign     (misalign)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wb_valid && wb_ready) wb_count++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int wb0;
        @(negedge clk);
        chk($sformatf("v%0d_ld_ready", idx), {31'b0, ld_ready}, 32'd1);
        ld_valid = 1'b1; load_control = v.ctrl; rs1_data = v.rs1; imm = v.imm; rd = v.rd;
        wb0 = wb_count;
        @(negedge clk);
        ld_valid = 1'b0; load_control = LD_NOP;
        chk($sformatf("v%0d_req", idx), {31'b0, mem_req}, 32'd1);
        chk($sformatf("v%0d_addr", idx), mem_addr, v.addr);
        for (int i = 0; i < v.gnt_dly; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d_req_hold", idx), {31'b0, mem_req}, 32'd1);
            chk($sformatf("v%0d_addr_hold", idx), mem_addr, v.addr);
        end
        // rvalid alongside gnt carries junk that must be ignored.
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5A5A_5A5A;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rdata = v.word;
        chk($sformatf("v%0d_req_drop", idx), {31'b0, mem_req}, 32'd0);
        chk($sformatf("v%0d_wbv_wait", idx), {31'b0, wb_valid}, 32'd0);
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = 32'hA5A5_A5A5;
        chk($sformatf("v%0d_wb_valid", idx), {31'b0, wb_valid}, 32'd1);
        chk($sformatf("v%0d_wb_data", idx), wb_data, v.data);
        chk($sformatf("v%0d_wb_rd", idx), {27'b0, wb_rd}, {27'b0, v.rd});
        chk($sformatf("v%0d_ld_ready_resp", idx), {31'b0, ld_ready}, 32'd0);
        chk($sformatf("v%0d_misalign", idx), {31'b0, misalign}, 32'd0);
        for (int i = 0; i < v.rdy_dly; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d_wbv_hold", idx), {31'b0, wb_valid}, 32'd1);
            chk($sformatf("v%0d_wbd_hold", idx), wb_data, v.data);
        end
        wb_ready = 1'b1;
        chk($sformatf("v%0d_ld_ready_handoff", idx), {31'b0, ld_ready}, 32'd0);
        @(negedge clk);
        wb_ready = 1'b0;
        chk($sformatf("v%0d_wbv_done", idx), {31'b0, wb_valid}, 32'd0);
        chk($sformatf("v%0d_ld_ready_after", idx), {31'b0, ld_ready}, 32'd1);
        chk($sformatf("v%0d_wb_count", idx), wb_count - wb0, 32'd1);
        $display("vector %0d: ctrl=%0d ea_addr=0x%08h wb_data=0x%08h", idx, v.ctrl, v.addr, v.data);
    endtask

    initial begin
        int wb0;
        vecs[0] = '{LW,  32'h0000_1000, 12'h004, 5'd5,  32'hDEAD_BEEF, 32'h0000_1004, 32'hDEAD_BEEF, 0, 0};
        vecs[1] = '{LB,  32'h0000_2000, 12'h003, 5'd7,  32'h80FF_0000, 32'h0000_2000, 32'hFFFF_FF80, 0, 0};
        vecs[2] = '{LBU, 32'h0000_2000, 12'h003, 5'd8,  32'h80FF_0000, 32'h0000_2000, 32'h0000_0080, 0, 0};
        vecs[3] = '{LH,  32'h0000_0010, 12'hFFE, 5'd0,  32'h8001_1234, 32'h0000_000C, 32'hFFFF_8001, 0, 0};
        vecs[4] = '{LW,  32'hFFFF_FFFC, 12'h008, 5'd9,  32'h1234_5678, 32'h0000_0004, 32'h1234_5678, 3, 2};
        vecs[5] = '{LHU, 32'h0000_0100, 12'h002, 5'd10, 32'hABCD_0000, 32'h0000_0100, 32'h0000_ABCD, 1, 0};
        vecs[6] = '{LB,  32'h0000_0301, 12'h000, 5'd11, 32'h0000_7F00, 32'h0000_0300, 32'h0000_007F, 0, 1};
        vecs[7] = '{LBU, 32'h0000_0400, 12'hFFF, 5'd31, 32'hC300_0000, 32'h0000_03FC, 32'h0000_00C3, 0, 0};

        reset = 1'b1; ld_valid = 1'b0; rs1_data = '0; imm = '0; rd = '0;
        load_control = LD_NOP; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; wb_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_mem_req",  {31'b0, mem_req},  32'd0);
        chk("rst_mem_addr", mem_addr,          32'd0);
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst_wb_rd",    {27'b0, wb_rd},    32'd0);
        chk("rst_wb_data",  wb_data,           32'd0);
        chk("rst_misalign", {31'b0, misalign}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ld_ready", {31'b0, ld_ready}, 32'd1);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // LD_NOP presented: nothing happens.
        @(negedge clk);
        wb0 = wb_count;
        ld_valid = 1'b1; load_control = LD_NOP; rs1_data = 32'h0000_0800;
        @(negedge clk);
        ld_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("nop_mem_req",  {31'b0, mem_req},  32'd0);
            chk("nop_wb_valid", {31'b0, wb_valid}, 32'd0);
            chk("nop_ld_ready", {31'b0, ld_ready}, 32'd1);
            @(negedge clk);
        end
        chk("nop_wb_count", wb_count - wb0, 32'd0);
        $display("sequence LD_NOP done");

        // Reset while waiting for rvalid; the late rvalid must not write back.
        wb0 = wb_count;
        ld_valid = 1'b1; load_control = LW; rs1_data = 32'h0000_0500; imm = 12'h000; rd = 5'd3;
        @(negedge clk);
        ld_valid = 1'b0; load_control = LD_NOP; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstw_mem_req",  {31'b0, mem_req},  32'd0);
        chk("rstw_ld_ready", {31'b0, ld_ready}, 32'd1);
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("rstw_wb_valid",   {31'b0, wb_valid}, 32'd0);
        chk("rstw_ld_ready2",  {31'b0, ld_ready}, 32'd1);
        @(negedge clk);
        chk("rstw_wb_valid2",  {31'b0, wb_valid}, 32'd0);
        chk("rstw_wb_count",   wb_count - wb0,    32'd0);
        $display("sequence reset-in-WAIT done");

`ifdef LD_MISALIGN_CHECK_EN
        wb0 = wb_count;
        ld_valid = 1'b1; load_control = LW; rs1_data = 32'h0000_1000; imm = 12'h002; rd = 5'd4;
        @(negedge clk);
        ld_valid = 1'b0; load_control = LD_NOP;
        chk("mis_pulse",   {31'b0, misalign}, 32'd1);
        chk("mis_req",     {31'b0, mem_req},  32'd0);
        @(negedge clk);
        chk("mis_pulse_end", {31'b0, misalign}, 32'd0);
        chk("mis_req2",      {31'b0, mem_req},  32'd0);
        chk("mis_ld_ready",  {31'b0, ld_ready}, 32'd1);
        @(negedge clk);
        chk("mis_req3",      {31'b0, mem_req},  32'd0);
        chk("mis_wb_count",  wb_count - wb0,    32'd0);
        $display("sequence misaligned LW (check enabled) done");
`else
        run_vec('{LW, 32'h0000_1000, 12'h002, 5'd4, 32'hCAFE_F00D, 32'h0000_1000, 32'hCAFE_F00D, 0, 0}, 8);
        $display("sequence misaligned LW (check disabled) done");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
